// File: rtl/spi_tx_buffered.sv
// SPI peripheral transmitter in the system clock domain: oversampled sck/csn,
// all four SPI modes, MSB/LSB-first, fed from a small word FIFO.
module spi_tx_buffered #(
    parameter int             pBits     = 8,
    parameter int             pDepth    = 4,
    parameter int             pCpol     = 0,
    parameter int             pCpha     = 0,
    parameter int             pLsbFirst = 0,
    parameter logic [pBits-1:0] pFill   = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sck,
    input  logic                      csn,
    output logic                      sdo,
    input  logic [pBits-1:0]          wr_data,
    input  logic                      wr_stb,
    output logic                      wr_ready,
    output logic [$clog2(pDepth):0]   level,
    output logic                      word_done,
    output logic                      underrun,
    output logic                      abort
);
    localparam int AW = $clog2(pDepth);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(pBits);
    localparam logic [CW-1:0] DEPTH = CW'(pDepth);
    localparam logic [BW-1:0] LAST  = BW'(pBits - 1);
    localparam logic CPOL = pCpol[0];
    localparam logic CPHA = pCpha[0];
    localparam logic LSBF = pLsbFirst[0];

    typedef enum logic {IDLE, SHIFT} state_t;

    logic sck_s1_q, sck_s2_q, sck_h_q;
    logic csn_s1_q, csn_s2_q, csn_h_q;
    logic leading, trailing, selecting, deselecting;

    state_t state_q, state_d;
    logic [pBits-1:0] shreg_q, shreg_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic sdo_q, sdo_d;
    logic loaded_q, loaded_d;
    logic word_done_q, word_done_d;
    logic underrun_q, underrun_d;
    logic abort_q, abort_d;
    logic load;

    logic [pBits-1:0] mem_q [pDepth];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic wr_ready_q;
    logic push, pop;
    logic [pBits-1:0] load_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s1_q <= CPOL;
            sck_s2_q <= CPOL;
            sck_h_q  <= CPOL;
            csn_s1_q <= 1'b1;
            csn_s2_q <= 1'b1;
            csn_h_q  <= 1'b1;
        end else begin
            sck_s1_q <= sck;
            sck_s2_q <= sck_s1_q;
            sck_h_q  <= sck_s2_q;
            csn_s1_q <= csn;
            csn_s2_q <= csn_s1_q;
            csn_h_q  <= csn_s2_q;
        end
    end

    assign leading     = (sck_h_q == CPOL) && (sck_s2_q != CPOL);
    assign trailing    = (sck_h_q != CPOL) && (sck_s2_q == CPOL);
    assign selecting   = !csn_s2_q && csn_h_q;
    assign deselecting = csn_s2_q && !csn_h_q;

    // No bypass: an empty FIFO yields the fill word even if a push lands this cycle.
    assign push      = wr_stb && wr_ready_q;
    assign pop       = load && (count_q != '0);
    assign load_word = (count_q != '0) ? mem_q[rptr_q] : pFill;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            wr_ready_q <= 1'b1;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            count_q    <= count_d;
            wr_ready_q <= (count_d != DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        sdo_d       = sdo_q;
        loaded_d    = loaded_q;
        word_done_d = 1'b0;
        abort_d     = 1'b0;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                sdo_d = 1'b0;
                if (selecting) begin
                    state_d  = SHIFT;
                    loaded_d = 1'b0;
                    cnt_d    = '0;
                    load     = !CPHA;
                end
            end
            default: begin
                if (deselecting) begin
                    state_d  = IDLE;
                    sdo_d    = 1'b0;
                    loaded_d = 1'b0;
                    abort_d  = CPHA ? (loaded_q && cnt_q != '0) : (cnt_q != LAST);
                end else if ((!CPHA && trailing) || (CPHA && leading)) begin
                    if (cnt_q == '0) begin
                        load        = 1'b1;
                        word_done_d = !CPHA;
                    end else begin
                        cnt_d = cnt_q - BW'(1);
                        if (LSBF) begin
                            shreg_d = {1'b0, shreg_q[pBits-1:1]};
                            sdo_d   = shreg_q[1];
                        end else begin
                            shreg_d = {shreg_q[pBits-2:0], 1'b0};
                            sdo_d   = shreg_q[pBits-2];
                        end
                    end
                end else if (CPHA && trailing && cnt_q == '0 && loaded_q) begin
                    word_done_d = 1'b1;
                end
            end
        endcase
        if (load) begin
            shreg_d  = load_word;
            sdo_d    = LSBF ? load_word[0] : load_word[pBits-1];
            cnt_d    = LAST;
            loaded_d = 1'b1;
        end
    end

    assign underrun_d = load && (count_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sdo_q       <= 1'b0;
            loaded_q    <= 1'b0;
            word_done_q <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sdo_q       <= sdo_d;
            loaded_q    <= loaded_d;
            word_done_q <= word_done_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign sdo       = sdo_q;
    assign wr_ready  = wr_ready_q;
    assign level     = count_q;
    assign word_done = word_done_q;
    assign underrun  = underrun_q;
    assign abort     = abort_q;
endmodule

// File: tb/tb_spi_tx_buffered.sv
// Bench for spi_tx_buffered: a mode-0 MSB-first instance with fill FF and a
// mode-3 LSB-first instance, driven by a bit-banged SPI controller model.
module tb_spi_tx_buffered;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic sck0 = 1'b0, csn0 = 1'b1, wr_stb0 = 1'b0;
    logic [7:0] wr_data0 = '0;
    logic sdo0, wr_ready0, word_done0, underrun0, abort0;
    logic [2:0] level0;

    logic sck3 = 1'b1, csn3 = 1'b1, wr_stb3 = 1'b0;
    logic [7:0] wr_data3 = '0;
    logic sdo3, wr_ready3, word_done3, underrun3, abort3;
    logic [2:0] level3;

    spi_tx_buffered #(.pBits(8), .pDepth(4), .pCpol(0), .pCpha(0), .pLsbFirst(0), .pFill(8'hFF)) u0 (
        .clk(clk), .rst_n(rst_n), .sck(sck0), .csn(csn0), .sdo(sdo0),
        .wr_data(wr_data0), .wr_stb(wr_stb0), .wr_ready(wr_ready0), .level(level0),
        .word_done(word_done0), .underrun(underrun0), .abort(abort0));

    spi_tx_buffered #(.pBits(8), .pDepth(4), .pCpol(1), .pCpha(1), .pLsbFirst(1), .pFill(8'h00)) u3 (
        .clk(clk), .rst_n(rst_n), .sck(sck3), .csn(csn3), .sdo(sdo3),
        .wr_data(wr_data3), .wr_stb(wr_stb3), .wr_ready(wr_ready3), .level(level3),
        .word_done(word_done3), .underrun(underrun3), .abort(abort3));

    int n_tests = 0;
    int n_fail  = 0;
    int wd0_cnt = 0, ur0_cnt = 0, ab0_cnt = 0, wd3_cnt = 0, ab3_cnt = 0;
    logic [7:0] exp_q[$];

    // Pulse counters count high cycles, so a stretched pulse over-counts.
    always @(negedge clk) begin
        if (rst_n) begin
            if (word_done0) wd0_cnt <= wd0_cnt + 1;
            if (underrun0)  ur0_cnt <= ur0_cnt + 1;
            if (abort0)     ab0_cnt <= ab0_cnt + 1;
            if (word_done3) wd3_cnt <= wd3_cnt + 1;
            if (abort3)     ab3_cnt <= ab3_cnt + 1;
        end
    end

    typedef struct {
        logic [7:0] w0;
        logic [7:0] w1;
        int         lvl;
        int         wd;
    } vec_t;
    vec_t vt[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push0(input logic [7:0] d);
        wr_data0 = d;
        wr_stb0  = 1'b1;
        tick(1);
        wr_stb0  = 1'b0;
        if (exp_q.size() < 4) exp_q.push_back(d);
    endtask

    task automatic shift0(input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            rx   = {rx[6:0], sdo0};
            sck0 = 1'b1;
            tick(6);
            sck0 = 1'b0;
            tick(6);
        end
    endtask

    task automatic recv0(input int nwords);
        logic [7:0] rx;
        logic [7:0] e;
        for (int w = 0; w < nwords; w++) begin
            shift0(8, rx);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_word: got %0h expected nothing (scoreboard empty)", rx);
            end else begin
                e = exp_q.pop_front();
                check("sb_word", {24'd0, rx}, {24'd0, e});
            end
        end
    endtask

    task automatic select0();
        csn0 = 1'b0;
        tick(8);
    endtask

    task automatic deselect0();
        csn0 = 1'b1;
        tick(8);
    endtask

    initial begin
        int wd, ur, ab;
        logic [7:0] rx;

        vt[0] = '{w0: 8'hA5, w1: 8'h3C, lvl: 2, wd: 2};
        vt[1] = '{w0: 8'h00, w1: 8'hFF, lvl: 2, wd: 2};
        vt[2] = '{w0: 8'h81, w1: 8'h7E, lvl: 2, wd: 2};

        tick(3);
        check("rst_sdo0", sdo0, 0);
        check("rst_wr_ready0", wr_ready0, 1);
        check("rst_level0", level0, 0);
        check("rst_pulses0", {word_done0, underrun0, abort0}, 0);
        check("rst_sdo3", sdo3, 0);
        check("rst_level3", level3, 0);
        rst_n = 1'b1;
        tick(2);

        for (int v = 0; v < 3; v++) begin
            push0(vt[v].w0);
            push0(vt[v].w1);
            tick(1);
            check("vec_level_push", level0, vt[v].lvl);
            wd = wd0_cnt;
            ab = ab0_cnt;
            select0();
            recv0(2);
            deselect0();
            check("vec_level_end", level0, 0);
            check("vec_word_done", wd0_cnt - wd, vt[v].wd);
            check("vec_no_abort", ab0_cnt - ab, 0);
        end

        ur = ur0_cnt;
        csn0 = 1'b0;
        tick(8);
        check("underrun_at_load", ur0_cnt - ur, 1);
        exp_q.push_back(8'hFF);
        recv0(1);
        deselect0();

        for (int i = 0; i < 5; i++) begin
            wr_data0 = 8'h50 + 8'(i);
            wr_stb0  = 1'b1;
            tick(1);
            if (exp_q.size() < 4) exp_q.push_back(wr_data0);
            if (i == 3) check("full_ready_after4", wr_ready0, 0);
        end
        wr_stb0 = 1'b0;
        tick(1);
        check("full_level", level0, 4);
        check("full_ready", wr_ready0, 0);
        csn0     = 1'b0;
        wr_data0 = 8'hEE;
        wr_stb0  = 1'b1;
        tick(3);
        wr_stb0  = 1'b0;
        tick(5);
        check("full_pop_push_level", level0, 3);
        check("full_pop_ready", wr_ready0, 1);
        recv0(4);
        deselect0();
        check("full_drain_level", level0, 0);

        push0(8'h11);
        push0(8'h22);
        ab = ab0_cnt;
        select0();
        shift0(3, rx);
        check("abort_partial_bits", rx[2:0], 3'b000);
        csn0 = 1'b1;
        tick(6);
        check("abort_pulse", ab0_cnt - ab, 1);
        check("abort_sdo", sdo0, 0);
        void'(exp_q.pop_front());
        tick(2);
        select0();
        recv0(1);
        deselect0();
        check("abort_level", level0, 0);

        push0(8'h33);
        push0(8'h44);
        select0();
        shift0(5, rx);
        rst_n = 1'b0;
        tick(1);
        csn0 = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("midrst_sdo", sdo0, 0);
        check("midrst_ready", wr_ready0, 1);
        check("midrst_level", level0, 0);
        check("midrst_pulses", {word_done0, underrun0, abort0}, 0);
        exp_q.delete();
        ur = ur0_cnt;
        csn0 = 1'b0;
        tick(8);
        check("midrst_underrun", ur0_cnt - ur, 1);
        exp_q.push_back(8'hFF);
        recv0(1);
        deselect0();

        wr_data3 = 8'h01;
        wr_stb3  = 1'b1;
        tick(1);
        wr_stb3  = 1'b0;
        tick(1);
        check("m3_level", level3, 1);
        wd = wd3_cnt;
        ab = ab3_cnt;
        csn3 = 1'b0;
        tick(8);
        for (int i = 0; i < 8; i++) begin
            sck3 = 1'b0;
            tick(6);
            check("m3_bit", sdo3, (i == 0) ? 1 : 0);
            sck3 = 1'b1;
            tick(6);
        end
        check("m3_word_done", wd3_cnt - wd, 1);
        check("m3_level_end", level3, 0);
        csn3 = 1'b1;
        tick(8);
        check("m3_no_abort", ab3_cnt - ab, 0);
        check("m3_sdo_idle", sdo3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
